wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning writeback FIFO entries; power of 2, >=2.
REQ-002 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-003 SHALL have port nrst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port alu_valid  input  1  ALU result write request.
REQ-005 SHALL have port alu_addr  input  4  ALU destination register.
REQ-006 SHALL have port alu_data  input  32  ALU result.
REQ-007 SHALL have port alu_ready  output  1  ALU request accepted this cycle when high with alu_valid.
REQ-008 SHALL have port mem_valid  input  1  load-unit write request.
REQ-009 SHALL have port mem_addr  input  4  load destination register.
REQ-010 SHALL have port mem_data  input  32  loaded value.
REQ-011 SHALL have port mem_ready  output  1  load request accepted this cycle when high with mem_valid.
REQ-012 SHALL have port rf_wen  output  1  register-file write enable, registered.
REQ-013 SHALL have port rf_waddr  output  4  register-file write address, registered.
REQ-014 SHALL have port rf_wdata  output  32  register-file write data, registered.
REQ-015 SHALL have port qa_addr  input  4  decode read address A for hazard check.
REQ-016 SHALL have port qb_addr  input  4  decode read address B for hazard check.
REQ-017 SHALL have port hz_a  output  1  write to qa_addr pending, combinational.
REQ-018 SHALL have port hz_b  output  1  write to qb_addr pending, combinational.

Function
REQ-019 SHALL hold entries {addr[3:0], data[31:0]} in a circular FIFO: wr_ptr, rd_ptr wrap modulo DEPTH; count 0..DEPTH, width clog2(DEPTH+1).
REQ-020 SHALL compute free = DEPTH - count from registered count only; same-cycle dequeue gives no credit.
REQ-021 SHALL drive mem_ready = (free >= 1) and alu_ready = (free >= 2) or (free == 1 and !mem_valid); mem has priority.
REQ-022 SHALL treat a request as accepted iff valid and ready are both high at posedge; requester holds addr/data stable until accepted.
REQ-023 SHALL, when both are accepted in one cycle, enqueue mem first, then alu at wr_ptr+1; wr_ptr advances by 2, count by 2 (minus dequeue).
REQ-024 SHALL, each posedge with count > 0, pop head into rf_waddr/rf_wdata and set rf_wen = 1; with count == 0, set rf_wen = 0 and hold rf_waddr/rf_wdata.
REQ-025 SHALL update count = count + enqueued - dequeued, with simultaneous enqueue and dequeue in the same cycle legal, including when full (count == DEPTH: dequeue only) and empty (enqueue only).
REQ-026 SHALL give latency: request accepted at edge N -> rf_wen high for the cycle after edge N+1 if FIFO was empty, i.e. one entry per cycle, in strict acceptance order.
REQ-027 SHALL assert hz_a when rf_wen == 1 and rf_waddr == qa_addr, or any valid FIFO entry has addr == qa_addr; hz_b likewise for qb_addr.
REQ-028 SHALL treat register 0 like any other address (no hardwired zero).
REQ-029 SHALL never drop, duplicate or reorder an accepted entry; overflow/underflow are unreachable by construction.

Reset
REQ-030 SHALL, while nrst is low at posedge, clear count, wr_ptr, rd_ptr, rf_wen, rf_waddr (4'h0), rf_wdata (32'h0); FIFO storage need not clear.
REQ-031 SHALL force alu_ready = mem_ready = 0, hz_a = hz_b = 0 while nrst is low.
REQ-032 SHALL, on reset mid-operation, discard all queued entries; first edge after release behaves as empty.

Verification
REQ-033 Single ALU write r3=0x12345678 into empty FIFO at edge N -> rf_wen=1, rf_waddr=3, rf_wdata=0x12345678 during cycle after N+1, then rf_wen=0.
REQ-034 Simultaneous mem r5=0xA, alu r6=0xB with FIFO empty -> both accepted, RF sees r5 then r6 on consecutive cycles.
REQ-035 Fill to DEPTH=4 with no drain opportunity exhausted -> mem_ready=0, alu_ready=0 at count 4; free==1 with both valid -> only mem accepted, alu retried next cycle.
REQ-036 Queue r7 pending, qa_addr=7, qb_addr=2 -> hz_a=1, hz_b=0; hz_a stays 1 through the cycle rf_wen=1 for r7, 0 after.
REQ-037 Reset asserted with 3 entries queued -> next cycle count=0, rf_wen=0, readies 0; after release no stale write appears.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and load-unit writes into an in-order FIFO
// that drains one entry per cycle into the register file, with hazard lookup.
module wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        alu_valid,
    input  logic [3:0]  alu_addr,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [3:0]  mem_addr,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic        rf_wen,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    input  logic [3:0]  qa_addr,
    input  logic [3:0]  qb_addr,
    output logic        hz_a,
    output logic        hz_b
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rf_wen_q, rf_wen_d;
    logic [3:0]    rf_waddr_q, rf_waddr_d;
    logic [31:0]   rf_wdata_q, rf_wdata_d;
    logic [3:0]    ent_addr_q [DEPTH];
    logic [3:0]    ent_addr_d [DEPTH];
    logic [31:0]   ent_data_q [DEPTH];
    logic [31:0]   ent_data_d [DEPTH];
    logic [PW-1:0] ent_off [DEPTH];

    logic [CW-1:0] free;
    logic          mem_acc;
    logic          alu_acc;
    logic          deq;
    logic [PW-1:0] alu_idx;
    logic          hit_a;
    logic          hit_b;

    // Credit comes only from the registered count; a same-cycle pop is not reused.
    assign free      = CW'(DEPTH) - count_q;
    assign mem_ready = nrst && (free >= CW'(1));
    assign alu_ready = nrst && ((free >= CW'(2)) ||
                                ((free == CW'(1)) && !mem_valid));
    assign mem_acc   = mem_valid && mem_ready;
    assign alu_acc   = alu_valid && alu_ready;
    assign deq       = (count_q != '0);
    assign alu_idx   = wr_ptr_q + PW'(mem_acc);

    always_comb begin
        wr_ptr_d   = wr_ptr_q + PW'(mem_acc) + PW'(alu_acc);
        rd_ptr_d   = rd_ptr_q + PW'(deq);
        count_d    = count_q + CW'(mem_acc) + CW'(alu_acc) - CW'(deq);
        rf_wen_d   = deq;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (deq) begin
            rf_waddr_d = ent_addr_q[rd_ptr_q];
            rf_wdata_d = ent_data_q[rd_ptr_q];
        end
        if (!nrst) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            rf_wen_d   = 1'b0;
            rf_waddr_d = 4'h0;
            rf_wdata_d = 32'h0;
        end
    end

    // Mem is placed first when both requesters are accepted together.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            ent_addr_d[j] = ent_addr_q[j];
            ent_data_d[j] = ent_data_q[j];
            if (mem_acc && (wr_ptr_q == PW'(j))) begin
                ent_addr_d[j] = mem_addr;
                ent_data_d[j] = mem_data;
            end
            if (alu_acc && (alu_idx == PW'(j))) begin
                ent_addr_d[j] = alu_addr;
                ent_data_d[j] = alu_data;
            end
        end
    end

    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            ent_off[j] = PW'(j) - rd_ptr_q;
            if (CW'(ent_off[j]) < count_q) begin
                if (ent_addr_q[j] == qa_addr) hit_a = 1'b1;
                if (ent_addr_q[j] == qb_addr) hit_b = 1'b1;
            end
        end
    end

    assign hz_a = nrst && (hit_a || (rf_wen_q && (rf_waddr_q == qa_addr)));
    assign hz_b = nrst && (hit_b || (rf_wen_q && (rf_waddr_q == qb_addr)));

    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    always_ff @(posedge clk) begin
        wr_ptr_q   <= wr_ptr_d;
        rd_ptr_q   <= rd_ptr_d;
        count_q    <= count_d;
        rf_wen_q   <= rf_wen_d;
        rf_waddr_q <= rf_waddr_d;
        rf_wdata_q <= rf_wdata_d;
    end

    always_ff @(posedge clk) begin
        ent_addr_q <= ent_addr_d;
        ent_data_q <= ent_data_d;
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, then random traffic
// compared against a queue-based model of the writeback path.
module tb_wb_arbiter;

    localparam int DEPTH = 4;

    logic        clk;
    logic        nrst;
    logic        alu_valid;
    logic [3:0]  alu_addr;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [3:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        rf_wen;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [3:0]  qa_addr;
    logic [3:0]  qb_addr;
    logic        hz_a;
    logic        hz_b;

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .nrst(nrst),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
        .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_ready(mem_ready),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .qa_addr(qa_addr), .qb_addr(qb_addr), .hz_a(hz_a), .hz_b(hz_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        n;
        logic        av;
        logic [3:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [3:0]  ma;
        logic [31:0] md;
        logic [3:0]  qa;
        logic [3:0]  qb;
        logic        ear;
        logic        emr;
        logic        ew;
        logic [3:0]  ewa;
        logic [31:0] ewd;
        logic        eha;
        logic        ehb;
    } vec_t;

    vec_t tbl [27];

    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic        m_wen;
    logic [3:0]  m_waddr;
    logic [31:0] m_wdata;

    function automatic logic pending(input logic [3:0] r);
        logic hit;
        hit = m_wen && (m_waddr == r);
        foreach (mq[i]) if (mq[i].a == r) hit = 1'b1;
        return hit;
    endfunction

    task automatic drive(input vec_t v);
        nrst      = v.n;
        alu_valid = v.av;
        alu_addr  = v.aa;
        alu_data  = v.ad;
        mem_valid = v.mv;
        mem_addr  = v.ma;
        mem_data  = v.md;
        qa_addr   = v.qa;
        qb_addr   = v.qb;
    endtask

    initial begin
        logic a_pend, m_pend;
        logic ear, emr;
        int   free;
        ent_t e;

        tbl[0]  = '{1,0,0,0,0,0,0,3,0, 1,1,0,0,0,0,0};
        tbl[1]  = '{1,1,3,32'h12345678,0,0,0,3,0, 1,1,0,0,0,0,0};
        tbl[2]  = '{1,0,0,0,0,0,0,3,0, 1,1,0,0,0,1,0};
        tbl[3]  = '{1,0,0,0,0,0,0,3,0, 1,1,1,3,32'h12345678,1,0};
        tbl[4]  = '{1,1,6,32'hB,1,5,32'hA,5,6, 1,1,0,3,32'h12345678,0,0};
        tbl[5]  = '{1,0,0,0,0,0,0,5,6, 1,1,0,3,32'h12345678,1,1};
        tbl[6]  = '{1,0,0,0,0,0,0,5,6, 1,1,1,5,32'hA,1,1};
        tbl[7]  = '{1,0,0,0,0,0,0,5,6, 1,1,1,6,32'hB,0,1};
        tbl[8]  = '{1,1,2,32'h102,1,1,32'h101,0,0, 1,1,0,6,32'hB,0,0};
        tbl[9]  = '{1,1,4,32'h104,1,3,32'h103,0,0, 1,1,0,6,32'hB,0,0};
        tbl[10] = '{1,1,7,32'h106,1,5,32'h105,0,0, 0,1,1,1,32'h101,0,0};
        tbl[11] = '{1,1,7,32'h106,0,0,0,0,0, 1,1,1,2,32'h102,0,0};
        tbl[12] = '{1,0,0,0,0,0,0,7,2, 1,1,1,3,32'h103,1,0};
        tbl[13] = '{1,0,0,0,0,0,0,7,2, 1,1,1,4,32'h104,1,0};
        tbl[14] = '{1,0,0,0,0,0,0,7,2, 1,1,1,5,32'h105,1,0};
        tbl[15] = '{1,0,0,0,0,0,0,7,2, 1,1,1,7,32'h106,1,0};
        tbl[16] = '{1,0,0,0,0,0,0,7,2, 1,1,0,7,32'h106,0,0};
        tbl[17] = '{1,1,9,32'h209,1,8,32'h208,10,11, 1,1,0,7,32'h106,0,0};
        tbl[18] = '{1,1,11,32'h20B,1,10,32'h20A,10,11, 1,1,0,7,32'h106,0,0};
        tbl[19] = '{0,1,13,32'h20D,1,12,32'h20C,10,11, 0,0,1,8,32'h208,0,0};
        tbl[20] = '{0,0,0,0,0,0,0,10,11, 0,0,0,0,0,0,0};
        tbl[21] = '{1,0,0,0,0,0,0,9,11, 1,1,0,0,0,0,0};
        tbl[22] = '{1,0,0,0,0,0,0,9,10, 1,1,0,0,0,0,0};
        tbl[23] = '{1,1,0,32'h55,0,0,0,0,0, 1,1,0,0,0,0,0};
        tbl[24] = '{1,0,0,0,0,0,0,0,0, 1,1,0,0,0,1,1};
        tbl[25] = '{1,0,0,0,0,0,0,0,0, 1,1,1,0,32'h55,1,1};
        tbl[26] = '{1,0,0,0,0,0,0,0,0, 1,1,0,0,32'h55,0,0};

        nrst = 1'b0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
        qa_addr = '0; qb_addr = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk($sformatf("t%0d alu_ready", i), 32'(alu_ready), 32'(tbl[i].ear));
            chk($sformatf("t%0d mem_ready", i), 32'(mem_ready), 32'(tbl[i].emr));
            chk($sformatf("t%0d rf_wen", i),    32'(rf_wen),    32'(tbl[i].ew));
            chk($sformatf("t%0d rf_waddr", i),  32'(rf_waddr),  32'(tbl[i].ewa));
            chk($sformatf("t%0d rf_wdata", i),  rf_wdata,       tbl[i].ewd);
            chk($sformatf("t%0d hz_a", i),      32'(hz_a),      32'(tbl[i].eha));
            chk($sformatf("t%0d hz_b", i),      32'(hz_b),      32'(tbl[i].ehb));
            @(posedge clk);
        end

        a_pend = 1'b0;
        m_pend = 1'b0;
        m_wen = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            nrst = (c < 2) ? 1'b0 : ($urandom_range(0, 99) != 0);
            if (!a_pend && ($urandom_range(0, 9) < 6)) begin
                a_pend   = 1'b1;
                alu_addr = 4'($urandom_range(0, 15));
                alu_data = $urandom;
            end
            if (!m_pend && ($urandom_range(0, 9) < 5)) begin
                m_pend   = 1'b1;
                mem_addr = 4'($urandom_range(0, 15));
                mem_data = $urandom;
            end
            alu_valid = a_pend;
            mem_valid = m_pend;
            qa_addr = 4'($urandom_range(0, 15));
            qb_addr = 4'($urandom_range(0, 15));
            #1;
            free = DEPTH - mq.size();
            emr = nrst && (free >= 1);
            ear = nrst && ((free >= 2) || ((free == 1) && !mem_valid));
            if (c >= 1) begin
                chk("r alu_ready", 32'(alu_ready), 32'(ear));
                chk("r mem_ready", 32'(mem_ready), 32'(emr));
                chk("r rf_wen",    32'(rf_wen),    32'(m_wen));
                chk("r rf_waddr",  32'(rf_waddr),  32'(m_waddr));
                chk("r rf_wdata",  rf_wdata,       m_wdata);
                chk("r hz_a", 32'(hz_a), 32'(nrst && pending(qa_addr)));
                chk("r hz_b", 32'(hz_b), 32'(nrst && pending(qb_addr)));
            end
            @(posedge clk);
            if (!nrst) begin
                mq.delete();
                m_wen = 1'b0;
                m_waddr = '0;
                m_wdata = '0;
            end else begin
                if (mq.size() > 0) begin
                    e = mq.pop_front();
                    m_wen = 1'b1;
                    m_waddr = e.a;
                    m_wdata = e.d;
                end else begin
                    m_wen = 1'b0;
                end
                if (mem_valid && emr) begin
                    mq.push_back('{mem_addr, mem_data});
                    m_pend = 1'b0;
                end
                if (alu_valid && ear) begin
                    mq.push_back('{alu_addr, alu_data});
                    a_pend = 1'b0;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
